// File: rtl/rv_pkg.sv
// Shared core definitions: word width, canonical NOP,
// fetch fault causes and fetch FSM states.
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_MISALIGN = 2'b01,
        FC_RANGE    = 2'b10
    } fault_cause_e;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: imem port, redirect input and IF/ID handshake.
interface fetch_stage_if;
    import rv_pkg::*;

    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_instr;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_instr;
    logic            halted;
    logic [1:0]      fault_cause;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  redirect_valid,
        input  redirect_target,
        output id_valid,
        input  id_ready,
        output id_pc,
        output id_instr,
        output halted,
        output fault_cause
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output redirect_valid,
        output redirect_target,
        input  id_valid,
        output id_ready,
        input  id_pc,
        input  id_instr,
        input  halted,
        input  fault_cause
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register; flush drops the entry and parks a NOP,
// otherwise it loads on load_i and holds.
module if_id_reg
    import rv_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] instr_i,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] instr_o
);

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, reads imem, fills IF/ID and
// halts on a misaligned redirect or an out-of-range fetch.
module fetch_stage
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 32
) (
    input logic          clk,
    input logic          rst,
    fetch_stage_if.master bus
);

    localparam logic [XLEN-1:0] IMEM_BYTES = XLEN'(IMEM_WORDS * 4);

    fetch_state_e    state_q, state_d;
    fault_cause_e    cause_q, cause_d;
    logic [XLEN-1:0] pc_q, pc_d;

    logic id_valid;
    logic advance;
    logic load;
    logic flush;
    logic redir_bad;
    logic redir_ok;
    logic range_bad;
    logic fetch_ok;

    assign advance   = !id_valid || bus.id_ready;
    assign redir_bad = bus.redirect_valid
                     && (bus.redirect_target[1:0] != 2'b00);
    assign redir_ok  = bus.redirect_valid
                     && (bus.redirect_target[1:0] == 2'b00);
    assign range_bad = !bus.redirect_valid && advance
                     && (pc_q >= IMEM_BYTES);
    assign fetch_ok  = !bus.redirect_valid && advance
                     && (pc_q < IMEM_BYTES);

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        pc_d    = pc_q;
        load    = 1'b0;
        flush   = 1'b0;
        if (state_q == FS_RUN) begin
            unique case (1'b1)
                redir_bad: begin
                    state_d = FS_HALT;
                    cause_d = FC_MISALIGN;
                    flush   = 1'b1;
                end
                redir_ok: begin
                    pc_d  = bus.redirect_target;
                    flush = 1'b1;
                end
                range_bad: begin
                    state_d = FS_HALT;
                    cause_d = FC_RANGE;
                    flush   = 1'b1;
                end
                fetch_ok: begin
                    pc_d = pc_q + 32'd4;
                    load = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FS_RUN;
            cause_q <= FC_NONE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
        end
    end

    if_id_reg u_if_id (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (load),
        .flush_i (flush),
        .pc_i    (pc_q),
        .instr_i (bus.imem_instr),
        .valid_o (id_valid),
        .pc_o    (bus.id_pc),
        .instr_o (bus.id_instr)
    );

    assign bus.imem_addr   = pc_q;
    assign bus.id_valid    = id_valid;
    assign bus.halted      = (state_q == FS_HALT);
    assign bus.fault_cause = cause_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table plus randomized
// traffic checked against a cycle-level reference model.
module tb_fetch_stage;
    import rv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC   (32'h0),
        .IMEM_WORDS (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [32];
    assign bus.imem_instr = mem[bus.imem_addr[6:2]];

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] tgt;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic        eh;
        logic [1:0]  ec;
        logic [31:0] eaddr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        logic r, logic rv, logic [31:0] t, logic rdy,
        logic ev, logic [31:0] pc, logic [31:0] ins,
        logic h, logic [1:0] c, logic [31:0] a);
        vec_t v;
        v.rst = r; v.rv = rv; v.tgt = t; v.rdy = rdy;
        v.ev = ev; v.epc = pc; v.einstr = ins;
        v.eh = h; v.ec = c; v.eaddr = a;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act,
                       logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(string tag, logic ev,
        logic [31:0] pc, logic [31:0] ins, logic h,
        logic [1:0] c, logic [31:0] a);
        chk({tag, ".valid"}, 32'(bus.id_valid), 32'(ev));
        if (ev) begin
            chk({tag, ".pc"}, bus.id_pc, pc);
        end
        chk({tag, ".instr"}, bus.id_instr, ins);
        chk({tag, ".halted"}, 32'(bus.halted), 32'(h));
        chk({tag, ".cause"}, 32'(bus.fault_cause), 32'(c));
        chk({tag, ".addr"}, bus.imem_addr, a);
    endtask

    task automatic drive(logic r, logic rv,
                         logic [31:0] t, logic rdy);
        rst                 = r;
        bus.redirect_valid  = rv;
        bus.redirect_target = t;
        bus.id_ready        = rdy;
    endtask

    // reference model state
    logic        m_valid, m_halt;
    logic [1:0]  m_cause;
    logic [31:0] m_pc, m_idpc, m_instr;

    task automatic model_step(logic r, logic rv,
                              logic [31:0] t, logic rdy);
        if (r) begin
            m_pc = 0; m_valid = 0; m_idpc = 0;
            m_instr = NOP_INSTR; m_halt = 0; m_cause = 0;
        end else if (!m_halt) begin
            if (rv && t[1:0] != 0) begin
                m_halt = 1; m_cause = 2'd1;
                m_valid = 0; m_instr = NOP_INSTR;
            end else if (rv) begin
                m_pc = t; m_valid = 0; m_instr = NOP_INSTR;
            end else if (!m_valid || rdy) begin
                if (m_pc >= 32 * 4) begin
                    m_halt = 1; m_cause = 2'd2;
                    m_valid = 0; m_instr = NOP_INSTR;
                end else begin
                    m_idpc = m_pc;
                    m_instr = mem[m_pc / 4];
                    m_valid = 1;
                    m_pc = m_pc + 4;
                end
            end
        end
    endtask

    initial begin
        logic [31:0] nop;
        nop = NOP_INSTR;
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
        mem[0] = 32'h0020_81B3;
        drive(1, 0, 0, 0);

        // directed vectors
        tbl.push_back(mk(1,0,0,1, 0,0,nop,0,0,0));
        tbl.push_back(mk(0,0,0,1, 1,0,32'h002081B3,0,0,4));
        tbl.push_back(mk(0,0,0,1, 1,4,32'h10000001,0,0,8));
        tbl.push_back(mk(0,0,0,0, 1,4,32'h10000001,0,0,8));
        tbl.push_back(mk(0,0,0,0, 1,4,32'h10000001,0,0,8));
        tbl.push_back(mk(0,0,0,0, 1,4,32'h10000001,0,0,8));
        tbl.push_back(mk(0,0,0,1, 1,8,32'h10000002,0,0,12));
        tbl.push_back(mk(0,0,0,0, 1,8,32'h10000002,0,0,12));
        tbl.push_back(mk(0,1,32'h40,0, 0,0,nop,0,0,32'h40));
        tbl.push_back(mk(0,0,0,0,
                         1,32'h40,32'h10000010,0,0,32'h44));
        tbl.push_back(mk(0,1,32'h42,1, 0,0,nop,1,1,32'h44));
        tbl.push_back(mk(0,1,32'h0,1, 0,0,nop,1,1,32'h44));
        tbl.push_back(mk(0,0,0,1, 0,0,nop,1,1,32'h44));
        tbl.push_back(mk(1,0,0,1, 0,0,nop,0,0,0));
        // sequential run to the end of memory
        for (int i = 0; i < 32; i++)
            tbl.push_back(mk(0,0,0,1, 1,32'(i*4),mem[i],
                             0,0,32'((i+1)*4)));
        tbl.push_back(mk(0,0,0,1, 0,0,nop,1,2,32'h80));
        tbl.push_back(mk(0,1,32'h8,1, 0,0,nop,1,2,32'h80));
        tbl.push_back(mk(1,0,0,0, 0,0,nop,0,0,0));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].rv, tbl[i].tgt, tbl[i].rdy);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), tbl[i].ev,
                    tbl[i].epc, tbl[i].einstr, tbl[i].eh,
                    tbl[i].ec, tbl[i].eaddr);
        end

        // redirect while handshaking: the entry is consumed, then flushed
        drive(0, 0, 0, 1);
        @(posedge clk); #1;
        drive(0, 1, 32'h10, 1);
        @(posedge clk); #1;
        chk_all("hs_redir", 0, 0, nop, 0, 0, 32'h10);
        drive(0, 0, 0, 0);
        @(posedge clk); #1;
        chk_all("hs_tgt", 1, 32'h10, mem[4], 0, 0, 32'h14);

        // randomized traffic against the model
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        drive(1, 0, 0, 0);
        model_step(1, 0, 0, 0);
        @(posedge clk); #1;
        for (int n = 0; n < 1500; n++) begin
            logic        r, rv, rdy;
            logic [31:0] t;
            int          k;
            r   = ($urandom_range(0, 99) < 3);
            rv  = ($urandom_range(0, 99) < 10);
            rdy = ($urandom_range(0, 99) < 70);
            k   = $urandom_range(0, 9);
            if (k < 7)      t = 32'($urandom_range(0, 31) * 4);
            else if (k < 8) t = 32'($urandom_range(0, 127)) | 32'h1;
            else if (k < 9) t = 32'h80 + 32'($urandom_range(0, 7) * 4);
            else            t = 32'hFFFF_FFFC;
            drive(r, rv, t, rdy);
            @(posedge clk);
            model_step(r, rv, t, rdy);
            #1;
            chk_all($sformatf("rnd%0d", n), m_valid, m_idpc,
                    m_instr, m_halt, m_cause, m_pc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the single-issue RISC-V core. Owns the program counter, drives the word address into the combinational instruction memory and captures the returned instruction into an IF/ID pipeline register. It presents that register to the decoder through a valid/ready handshake. It accepts branch/jump redirects, and halts on a misaligned or out-of-range fetch address.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 32, instruction memory depth in 32-bit words; legal byte addresses are 0 .. IMEM_WORDS*4-4.
- NOP_INSTR, 32'h0000_0013, value held in the IF/ID instruction register when it is not valid (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous and active-high.
- imem_addr  out  32  byte address to instruction memory; equals the current PC, combinational from the PC register.
- imem_instr  in  32  instruction returned combinationally for imem_addr in the same cycle.
- redirect_valid  in  1  branch/jump taken; load redirect_target.
- redirect_target  in  32  new PC byte address.
- id_valid  out  1  IF/ID register holds a live instruction.
- id_ready  in  1  decoder accepts the IF/ID contents this cycle.
- id_pc  out  32  PC of the instruction in IF/ID.
- id_instr  out  32  instruction in IF/ID.
- halted  out  1  fetch stopped on a fault; sticky until rst.
- fault_cause  out  2  00 none, 01 misaligned redirect, 10 PC out of range.

## Operation
- FSM states: RUN, HALT. Reset enters RUN.
- Reset values: PC=RESET_PC, id_valid=0, id_pc=0, id_instr=NOP_INSTR, halted=0, fault_cause=00.
- advance = !id_valid || id_ready.
- RUN, priority order, evaluated each cycle:
  - redirect_valid with redirect_target[1:0]!=0: go to HALT, fault_cause=01, id_valid<=0, PC unchanged.
  - redirect_valid with aligned target: PC<=redirect_target, id_valid<=0 (flush), id_instr<=NOP_INSTR. This applies regardless of id_ready. An entry handshaken in the same cycle counts as consumed.
  - No redirect, advance, PC >= IMEM_WORDS*4: go to HALT, fault_cause=10, id_valid<=0.
  - No redirect, advance, PC in range: id_pc<=PC, id_instr<=imem_instr, id_valid<=1, PC<=PC+4.
  - No redirect, !advance: all registers hold (stall).
- HALT:
  - id_valid stays 0.
  - PC, fault_cause and halted hold.
  - redirect_valid is ignored.
  - Only rst leaves HALT.
- halted is 1 exactly when the state is HALT.
- Arithmetic: PC+4 is 32-bit modulo; the range check fires before any wrap.
- imem_addr carries the full byte PC. The memory indexes with bits [log2(IMEM_WORDS)+1:2].

## Timing
- The first instruction becomes id_valid in cycle 1 after rst deasserts (one-cycle fetch latency). id_pc=RESET_PC.
- Steady state with id_ready=1 gives one instruction per cycle.
- Redirect at cycle N gives a bubble at N+1. The target instruction appears at N+2 (redirect penalty of one cycle in this stage).
- During a stall, id_pc/id_instr/id_valid are stable. imem_addr stays on the next PC.
- rst asserted in any state, including HALT or mid-stall, restores all reset values on the next edge.

## Structure
- Shared package rv_pkg holds:
  - NOP_INSTR constant.
  - Fault-cause enum (FC_NONE, FC_MISALIGN, FC_RANGE).
  - Fetch state enum (FS_RUN, FS_HALT).
  - XLEN=32.
- Natural sub-module: if_id_reg, the IF/ID pipeline register with valid, load, flush and hold controls. PC/FSM logic stays in fetch_stage.

## Test plan
- Reset then id_ready=1, memory preloaded with add x3,x1,x2 (32'h002081B3) at word 0 -> cycle 1: id_valid=1, id_pc=0, id_instr=32'h002081B3. Cycle 2: id_pc=4.
- Hold id_ready=0 for 3 cycles after the first valid -> id_pc/id_instr unchanged, imem_addr=4. Release -> id_pc=4 next cycle.
- redirect_valid with target 32'h40 while stalled -> next cycle id_valid=0. Following cycle id_pc=32'h40 and id_instr=mem[16].
- redirect_target=32'h42 -> halted=1, fault_cause=01, id_valid=0. A later aligned redirect is ignored.
- Run sequentially from 0 with IMEM_WORDS=32 -> the last valid is id_pc=32'h7C. Next cycle halted=1, fault_cause=10.
- Assert rst while in HALT -> next edge halted=0, fault_cause=00, id_valid=0, imem_addr=RESET_PC.
